mouse_uart_reporter: RTL

Sequences PS/2 mouse reports onto the serial debug UART. It captures each completed mouse packet (X, Y, buttons) and serialises it as a fixed-format ASCII hex frame. It drives the UART transmitter one byte at a time, waiting for each byte to finish before issuing the next. It sits between the `mouse` receiver and `UART_TX` in the debug top level and is the single owner of the UART's data-valid input.

---
 rtl/mouse_uart_reporter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/mouse_uart_reporter.sv
// mouse_uart_reporter: serialises PS/2 mouse packets as ASCII hex frames
// "XXX,YYY,B\n" onto a byte-wide UART transmitter, one byte per handshake.
// Optional macro MOUSE_REPORT_CRLF_EN inserts 0x0D before the final 0x0A.
// Ports:
//   clk_i, reset_i           : clock, synchronous active-high reset
//   x_i, y_i, btn_i, done_i  : mouse packet and its completion pulse
//   tx_busy_i                : UART shifting a byte
//   tx_byte_o, tx_dv_o       : byte to transmit and its one-cycle strobe
//   busy_o                   : frame in progress or pending
//   drop_cnt_o               : saturating count of overwritten reports
module mouse_uart_reporter #(
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [8:0] x_i,
    input  logic [8:0] y_i,
    input  logic [2:0] btn_i,
    input  logic       done_i,
    input  logic       tx_busy_i,
    output logic [7:0] tx_byte_o,
    output logic       tx_dv_o,
    output logic       busy_o,
    output logic [7:0] drop_cnt_o
);

`ifdef MOUSE_REPORT_CRLF_EN
    localparam logic [3:0] LAST_IDX = 4'd10;
`else
    localparam logic [3:0] LAST_IDX = 4'd9;
`endif

    localparam bit         GAP_EN   = (GAP_CYCLES != 0);
    localparam logic [15:0] GAP_LOAD = GAP_EN ? 16'(GAP_CYCLES - 1) : 16'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_HI,
        S_WAIT_LO,
        S_GAP
    } state_t;

    state_t      state_q;
    logic [3:0]  idx_q;
    logic [8:0]  snap_x_q, snap_y_q;
    logic [2:0]  snap_b_q;
    logic [8:0]  pend_x_q, pend_y_q;
    logic [2:0]  pend_b_q;
    logic        pend_q;
    logic [15:0] gap_q;
    logic [7:0]  tx_byte_q;
    logic        tx_dv_q;
    logic [7:0]  drop_q;

    logic [8:0]  ld_x_d, ld_y_d;
    logic [2:0]  ld_b_d;
    logic [7:0]  first_byte_d;
    logic [7:0]  next_byte_d;

    function automatic logic [7:0] hex(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [7:0] frame_byte(
        input logic [8:0] x,
        input logic [8:0] y,
        input logic [2:0] b,
        input logic [3:0] i
    );
        logic [7:0] r;
        case (i)
            4'd0:    r = hex({3'b000, x[8]});
            4'd1:    r = hex(x[7:4]);
            4'd2:    r = hex(x[3:0]);
            4'd3:    r = 8'h2C;
            4'd4:    r = hex({3'b000, y[8]});
            4'd5:    r = hex(y[7:4]);
            4'd6:    r = hex(y[3:0]);
            4'd7:    r = 8'h2C;
            4'd8:    r = hex({1'b0, b});
`ifdef MOUSE_REPORT_CRLF_EN
            4'd9:    r = 8'h0D;
`endif
            default: r = 8'h0A;
        endcase
        return r;
    endfunction

    // A waiting report is always older than one arriving now, so it wins.
    always_comb begin
        ld_x_d       = pend_q ? pend_x_q : x_i;
        ld_y_d       = pend_q ? pend_y_q : y_i;
        ld_b_d       = pend_q ? pend_b_q : btn_i;
        first_byte_d = frame_byte(ld_x_d, ld_y_d, ld_b_d, 4'd0);
        next_byte_d  = frame_byte(snap_x_q, snap_y_q, snap_b_q, idx_q + 4'd1);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            idx_q     <= 4'd0;
            snap_x_q  <= 9'd0;
            snap_y_q  <= 9'd0;
            snap_b_q  <= 3'd0;
            pend_x_q  <= 9'd0;
            pend_y_q  <= 9'd0;
            pend_b_q  <= 3'd0;
            pend_q    <= 1'b0;
            gap_q     <= 16'd0;
            tx_byte_q <= 8'h00;
            tx_dv_q   <= 1'b0;
            drop_q    <= 8'd0;
        end else begin
            tx_dv_q <= 1'b0;

            // Reports arriving while a frame is active (or while an older
            // one is being promoted) go to the pending slot.
            if (done_i && ((state_q != S_IDLE) || pend_q)) begin
                pend_x_q <= x_i;
                pend_y_q <= y_i;
                pend_b_q <= btn_i;
                pend_q   <= 1'b1;
            end
            if (done_i && (state_q != S_IDLE) && pend_q && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end

            case (state_q)
                S_IDLE: begin
                    if (done_i || pend_q) begin
                        snap_x_q  <= ld_x_d;
                        snap_y_q  <= ld_y_d;
                        snap_b_q  <= ld_b_d;
                        idx_q     <= 4'd0;
                        tx_byte_q <= first_byte_d;
                        tx_dv_q   <= 1'b1;
                        state_q   <= S_SEND;
                        if (pend_q && !done_i) begin
                            pend_q <= 1'b0;
                        end
                    end
                end
                S_SEND: begin
                    state_q <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (tx_busy_i) begin
                        state_q <= S_WAIT_LO;
                    end
                end
                S_WAIT_LO: begin
                    if (!tx_busy_i) begin
                        if (idx_q != LAST_IDX) begin
                            idx_q     <= idx_q + 4'd1;
                            tx_byte_q <= next_byte_d;
                            tx_dv_q   <= 1'b1;
                            state_q   <= S_SEND;
                        end else if (GAP_EN) begin
                            gap_q   <= GAP_LOAD;
                            state_q <= S_GAP;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_q == 16'd0) begin
                        state_q <= S_IDLE;
                    end else begin
                        gap_q <= gap_q - 16'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tx_byte_o  = tx_byte_q;
    assign tx_dv_o    = tx_dv_q;
    assign busy_o     = (state_q != S_IDLE) | pend_q;
    assign drop_cnt_o = drop_q;

endmodule
